// File: rtl/uart_tx_sched_if.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_sched_if
// Brief   : Requester handshake and UART register bus bundle for uart_tx_sched.
// Revision: 1.0 - initial release
// ============================================================================
interface uart_tx_sched_if;
    logic       req0;
    logic       req1;
    logic [7:0] data0;
    logic [7:0] data1;
    logic       ack0;
    logic       ack1;
    logic       cfg_done;
    logic       busy;
    logic       u_CS;
    logic       u_nRW;
    logic [2:0] u_add;
    logic [7:0] u_data_in;
    logic [7:0] u_data_out;

    modport master (
        output req0, req1, data0, data1, u_data_out,
        input  ack0, ack1, cfg_done, busy, u_CS, u_nRW, u_add, u_data_in
    );

    modport slave (
        input  req0, req1, data0, data1, u_data_out,
        output ack0, ack1, cfg_done, busy, u_CS, u_nRW, u_add, u_data_in
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_sched
// Brief   : Configures a 16550-style UART, then round-robin schedules single
//           byte transmissions from two requesters, polling LSR.THRE first.
// Revision: 1.0 - initial release
// ============================================================================
module uart_tx_sched #(
    parameter int DIVISOR = 27
) (
    input  logic            clk,
    input  logic            reset,
    uart_tx_sched_if.slave  bus
);

    localparam logic [2:0]  S_CFG    = 3'd0;
    localparam logic [2:0]  S_IDLE   = 3'd1;
    localparam logic [2:0]  S_POLL   = 3'd2;
    localparam logic [2:0]  S_RDWAIT = 3'd3;
    localparam logic [2:0]  S_WRITE  = 3'd4;
    localparam logic [2:0]  S_DONE   = 3'd5;

    localparam logic [15:0] c_div      = 16'(DIVISOR);
    localparam logic [2:0]  c_add_thr  = 3'd0;
    localparam logic [2:0]  c_add_dlm  = 3'd1;
    localparam logic [2:0]  c_add_lcr  = 3'd3;
    localparam logic [2:0]  c_add_lsr  = 3'd5;
    localparam logic [7:0]  c_lcr_dlab = 8'h83;
    localparam logic [7:0]  c_lcr_8n1  = 8'h03;
    localparam logic [3:0]  c_cfg_end  = 4'd8;

    logic [2:0] r_state;
    logic [3:0] r_cfg_step;
    logic       r_last_grant;
    logic       r_idx;
    logic [7:0] r_byte;
    logic       r_cs;
    logic       r_nrw;
    logic [2:0] r_add;
    logic [7:0] r_din;
    logic       r_ack0;
    logic       r_ack1;
    logic       r_cfg_done;
    logic       r_busy;

    logic [2:0] w_cfg_add;
    logic [7:0] w_cfg_data;
    logic       w_any_req;
    logic       w_pick;

    // Even steps of the configuration counter strobe a write, odd steps release it.
    always_comb begin
        w_cfg_add  = c_add_lcr;
        w_cfg_data = c_lcr_8n1;
        case (r_cfg_step[2:1])
            2'd0: begin w_cfg_add = c_add_lcr; w_cfg_data = c_lcr_dlab;  end
            2'd1: begin w_cfg_add = c_add_thr; w_cfg_data = c_div[7:0];  end
            2'd2: begin w_cfg_add = c_add_dlm; w_cfg_data = c_div[15:8]; end
            default: begin w_cfg_add = c_add_lcr; w_cfg_data = c_lcr_8n1; end
        endcase
    end

    assign w_any_req = bus.req0 | bus.req1;
    assign w_pick    = (bus.req0 & bus.req1) ? ~r_last_grant : bus.req1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_CFG;
            r_cfg_step   <= 4'd0;
            r_last_grant <= 1'b1;
            r_idx        <= 1'b0;
            r_byte       <= 8'h00;
            r_cs         <= 1'b0;
            r_nrw        <= 1'b0;
            r_add        <= 3'd0;
            r_din        <= 8'h00;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_cfg_done   <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            case (r_state)
                S_CFG: begin
                    if (r_cfg_step == c_cfg_end) begin
                        r_cfg_done <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_cfg_step <= r_cfg_step + 4'd1;
                        r_busy     <= 1'b1;
                        if (!r_cfg_step[0]) begin
                            r_cs  <= 1'b1;
                            r_nrw <= 1'b1;
                            r_add <= w_cfg_add;
                            r_din <= w_cfg_data;
                        end else begin
                            r_cs  <= 1'b0;
                            r_nrw <= 1'b0;
                        end
                    end
                end
                S_IDLE: begin
                    if (w_any_req) begin
                        r_idx   <= w_pick;
                        r_byte  <= w_pick ? bus.data1 : bus.data0;
                        r_cs    <= 1'b1;
                        r_nrw   <= 1'b0;
                        r_add   <= c_add_lsr;
                        r_busy  <= 1'b1;
                        r_state <= S_POLL;
                    end
                end
                S_POLL: begin
                    r_cs    <= 1'b0;
                    r_state <= S_RDWAIT;
                end
                S_RDWAIT: begin
                    // LSR data is valid now; either write THR or re-issue the LSR read.
                    r_cs <= 1'b1;
                    if (bus.u_data_out[5]) begin
                        r_nrw   <= 1'b1;
                        r_add   <= c_add_thr;
                        r_din   <= r_byte;
                        r_state <= S_WRITE;
                    end else begin
                        r_nrw   <= 1'b0;
                        r_add   <= c_add_lsr;
                        r_state <= S_POLL;
                    end
                end
                S_WRITE: begin
                    r_cs    <= 1'b0;
                    r_nrw   <= 1'b0;
                    r_ack0  <= ~r_idx;
                    r_ack1  <= r_idx;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_last_grant <= r_idx;
                    r_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_cs       <= 1'b0;
                    r_nrw      <= 1'b0;
                    r_cfg_step <= 4'd0;
                    r_cfg_done <= 1'b0;
                    r_busy     <= 1'b1;
                    r_state    <= S_CFG;
                end
            endcase
        end
    end

    assign bus.ack0      = r_ack0;
    assign bus.ack1      = r_ack1;
    assign bus.cfg_done  = r_cfg_done;
    assign bus.busy      = r_busy;
    assign bus.u_CS      = r_cs;
    assign bus.u_nRW     = r_nrw;
    assign bus.u_add     = r_add;
    assign bus.u_data_in = r_din;

endmodule
`default_nettype wire
